smc_counter_lite10: RTL and testbench
=====================================

SMC_COUNTER_LITE10 -- requirements
Module: smc_counter_lite10

Interface
REQ-001 SHALL have port sys_clk10, input, 1, AHB system clock; all flops on its rising edge.
REQ-002 SHALL have port n_sys_reset10, input, 1, system reset; asynchronous assertion, active-low.
REQ-003 SHALL have port valid_access10, input, 1, new access accepted by the state machine; loads the timing set.
REQ-004 SHALL have port smc_done10, input, 1, last cycle of the current sub-access; reloads the counters from the stores.
REQ-005 SHALL have port le_enable10, input, 1, decrement enable for the CS leading-edge counter.
REQ-006 SHALL have port ws_enable10, input, 1, decrement enable for the wait-state counter.
REQ-007 SHALL have port cste_enable10, input, 1, decrement enable for the CS trailing-edge counter.
REQ-008 SHALL have port cs, input, 1, chip select of the new access; 0 selects timing set 0, 1 selects timing set 1.
REQ-009 SHALL have ports t_csle0_10 and t_csle1_10, input, 2 each, CS leading-edge cycles for set 0 and set 1.
REQ-010 SHALL have ports t_ws0_10 and t_ws1_10, input, 8 each, wait-state cycles for set 0 and set 1.
REQ-011 SHALL have ports t_cste0_10 and t_cste1_10, input, 2 each, CS trailing-edge cycles for set 0 and set 1.
REQ-012 SHALL have ports t_oete0_10 and t_oete1_10, input, 2 each, read-strobe trailing-edge offset for set 0 and set 1.
REQ-013 SHALL have port r_csle_count10, output, 2, registered CS leading-edge counter.
REQ-014 SHALL have port r_ws_count10, output, 8, registered wait-state counter.
REQ-015 SHALL have port r_cste_count10, output, 2, registered CS trailing-edge counter.
REQ-016 SHALL have ports r_csle_store10 and r_oete_store10, output, 2 each, stored CSLE and OETE values of the active access.
REQ-017 SHALL have port r_ws_store10, output, 8, stored wait-state value of the active access.
REQ-018 SHALL have port r_cste_store10, output, 2, stored CSTE value of the active access.

Function
REQ-019 SHALL select the timing set combinationally from cs: set 1 when cs=1, otherwise set 0.
REQ-020 On valid_access10=1, SHALL load all four stores from the selected set on the next edge.
REQ-021 Stores SHALL hold their values in every cycle with valid_access10=0.
REQ-022 Each counter SHALL update per cycle using this priority, highest first:
        (a) valid_access10=1: load the selected set value.
        (b) smc_done10=1: reload from the matching store.
        (c) its enable=1 and count!=0: decrement by 1.
        (d) otherwise: hold.
REQ-023 The enables SHALL be le_enable10 for CSLE, ws_enable10 for WS and cste_enable10 for CSTE.
REQ-024 A counter at 0 with its enable high SHALL stay at 0; it SHALL never wrap to all-ones.
REQ-025 When valid_access10 and smc_done10 are both 1, the load SHALL use the new set values, not the old stores (back-to-back access).
REQ-026 The load SHALL take one edge: the value is visible on the count outputs in the cycle after valid_access10.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.
REQ-028 Set values SHALL be sampled only in cycles with valid_access10=1; changes at any other time SHALL have no effect.
REQ-029 Arithmetic SHALL be unsigned at each counter's native width (2 or 8 bits).

Reset
REQ-030 While n_sys_reset10=0, all counters and all stores SHALL be 0 immediately, independent of sys_clk10.
REQ-031 Reset asserted mid-access SHALL abandon the count; after release, counters SHALL stay 0 until the next valid_access10 or smc_done10.
REQ-032 Reset release SHALL be synchronous-safe: the first edge after release evaluates REQ-022 normally.

Verification
REQ-033 Apply reset mid-count with WS=0x40: all outputs go to 0 asynchronously and stay 0 after release with no stimulus.
REQ-034 cs=0, t_ws0_10=3, t_csle0_10=2, one valid_access10 pulse:
        - next cycle: r_ws_count10=3, r_csle_count10=2;
        - le_enable10 high 2 cycles: CSLE goes 1, 0;
        - ws_enable10 high 4 cycles: WS goes 2, 1, 0, 0.
REQ-035 cs=1, t_cste1_10=2, t_ws1_10=0, valid_access10, then cste_enable10 high 3 cycles -> CSTE goes 2, 1, 0, 0; r_cste_store10=2.
REQ-036 Multiple access with WS store=5: decrement WS to 0, pulse smc_done10 -> WS reloads to 5 next cycle; stores unchanged.
REQ-037 valid_access10 and smc_done10 together, with old set WS=5 and new cs=1 set WS=9 -> WS=9 and r_ws_store10=9 next cycle.
REQ-038 valid_access10 and ws_enable10 together with old WS=4, new WS=7 -> WS=7 (load wins over decrement).

Source files
------------

// File: rtl/smc_counter_lite10.sv
// Static memory controller timing counters: per-access CS leading-edge, wait-state
// and CS trailing-edge down-counters, loaded from one of two timing sets by chip select.
module smc_counter_lite10 (
  input  logic       sys_clk10,
  input  logic       n_sys_reset10,
  input  logic       valid_access10,
  input  logic       smc_done10,
  input  logic       le_enable10,
  input  logic       ws_enable10,
  input  logic       cste_enable10,
  input  logic       cs,
  input  logic [1:0] t_csle0_10,
  input  logic [1:0] t_csle1_10,
  input  logic [7:0] t_ws0_10,
  input  logic [7:0] t_ws1_10,
  input  logic [1:0] t_cste0_10,
  input  logic [1:0] t_cste1_10,
  input  logic [1:0] t_oete0_10,
  input  logic [1:0] t_oete1_10,
  output logic [1:0] r_csle_count10,
  output logic [7:0] r_ws_count10,
  output logic [1:0] r_cste_count10,
  output logic [1:0] r_csle_store10,
  output logic [1:0] r_oete_store10,
  output logic [7:0] r_ws_store10,
  output logic [1:0] r_cste_store10
);

  localparam int unsigned EDGE_W = 2;
  localparam int unsigned WS_W   = 8;

  logic [EDGE_W-1:0] sel_csle_c, sel_cste_c, sel_oete_c;
  logic [WS_W-1:0]   sel_ws_c;

  logic [EDGE_W-1:0] csle_cnt_q, csle_cnt_d;
  logic [WS_W-1:0]   ws_cnt_q,   ws_cnt_d;
  logic [EDGE_W-1:0] cste_cnt_q, cste_cnt_d;
  logic [EDGE_W-1:0] csle_st_q,  csle_st_d;
  logic [WS_W-1:0]   ws_st_q,    ws_st_d;
  logic [EDGE_W-1:0] cste_st_q,  cste_st_d;
  logic [EDGE_W-1:0] oete_st_q,  oete_st_d;

  // Timing set chosen by the chip select of the incoming access.
  always_comb begin
    sel_csle_c = cs ? t_csle1_10 : t_csle0_10;
    sel_ws_c   = cs ? t_ws1_10   : t_ws0_10;
    sel_cste_c = cs ? t_cste1_10 : t_cste0_10;
    sel_oete_c = cs ? t_oete1_10 : t_oete0_10;
  end

  // Stores capture the set only when an access is accepted.
  always_comb begin
    csle_st_d = csle_st_q;
    ws_st_d   = ws_st_q;
    cste_st_d = cste_st_q;
    oete_st_d = oete_st_q;
    if (valid_access10) begin
      csle_st_d = sel_csle_c;
      ws_st_d   = sel_ws_c;
      cste_st_d = sel_cste_c;
      oete_st_d = sel_oete_c;
    end
  end

  // Counter priority: new access load, sub-access reload, saturating decrement, hold.
  always_comb begin
    csle_cnt_d = csle_cnt_q;
    ws_cnt_d   = ws_cnt_q;
    cste_cnt_d = cste_cnt_q;
    if (valid_access10) begin
      csle_cnt_d = sel_csle_c;
      ws_cnt_d   = sel_ws_c;
      cste_cnt_d = sel_cste_c;
    end else if (smc_done10) begin
      csle_cnt_d = csle_st_q;
      ws_cnt_d   = ws_st_q;
      cste_cnt_d = cste_st_q;
    end else begin
      if (le_enable10 && (csle_cnt_q != '0)) csle_cnt_d = csle_cnt_q - EDGE_W'(1);
      if (ws_enable10 && (ws_cnt_q != '0))   ws_cnt_d   = ws_cnt_q - WS_W'(1);
      if (cste_enable10 && (cste_cnt_q != '0)) cste_cnt_d = cste_cnt_q - EDGE_W'(1);
    end
  end

  always_ff @(posedge sys_clk10 or negedge n_sys_reset10) begin
    if (!n_sys_reset10) begin
      csle_cnt_q <= '0;
      ws_cnt_q   <= '0;
      cste_cnt_q <= '0;
      csle_st_q  <= '0;
      ws_st_q    <= '0;
      cste_st_q  <= '0;
      oete_st_q  <= '0;
    end else begin
      csle_cnt_q <= csle_cnt_d;
      ws_cnt_q   <= ws_cnt_d;
      cste_cnt_q <= cste_cnt_d;
      csle_st_q  <= csle_st_d;
      ws_st_q    <= ws_st_d;
      cste_st_q  <= cste_st_d;
      oete_st_q  <= oete_st_d;
    end
  end

  assign r_csle_count10 = csle_cnt_q;
  assign r_ws_count10   = ws_cnt_q;
  assign r_cste_count10 = cste_cnt_q;
  assign r_csle_store10 = csle_st_q;
  assign r_ws_store10   = ws_st_q;
  assign r_cste_store10 = cste_st_q;
  assign r_oete_store10 = oete_st_q;

endmodule

// File: tb/tb_smc_counter_lite10.sv
// Bench for smc_counter_lite10: array-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_smc_counter_lite10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, done = 1'b0, le_en = 1'b0, ws_en = 1'b0, cste_en = 1'b0, cs = 1'b0;
  logic [1:0] csle0 = '0, csle1 = '0, cste0 = '0, cste1 = '0, oete0 = '0, oete1 = '0;
  logic [7:0] ws0 = '0, ws1 = '0;
  logic [1:0] csle_cnt, cste_cnt, csle_st, oete_st, cste_st;
  logic [7:0] ws_cnt, ws_st;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: index 0=CSLE, 1=WS, 2=CSTE, 3=OETE (stores only for OETE)
  int m_cnt[3];
  int m_store[4];
  int sel[4];
  logic [2:0] en;

  smc_counter_lite10 dut (
    .sys_clk10(clk), .n_sys_reset10(rst_n),
    .valid_access10(valid), .smc_done10(done),
    .le_enable10(le_en), .ws_enable10(ws_en), .cste_enable10(cste_en), .cs(cs),
    .t_csle0_10(csle0), .t_csle1_10(csle1), .t_ws0_10(ws0), .t_ws1_10(ws1),
    .t_cste0_10(cste0), .t_cste1_10(cste1), .t_oete0_10(oete0), .t_oete1_10(oete1),
    .r_csle_count10(csle_cnt), .r_ws_count10(ws_cnt), .r_cste_count10(cste_cnt),
    .r_csle_store10(csle_st), .r_oete_store10(oete_st),
    .r_ws_store10(ws_st), .r_cste_store10(cste_st)
  );

  always #5 clk = ~clk;

  always_comb begin
    sel[0] = cs ? int'(csle1) : int'(csle0);
    sel[1] = cs ? int'(ws1)   : int'(ws0);
    sel[2] = cs ? int'(cste1) : int'(cste0);
    sel[3] = cs ? int'(oete1) : int'(oete0);
    en     = {cste_en, ws_en, le_en};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_cnt[i] <= 0;
      for (int i = 0; i < 4; i++) m_store[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (valid)                        m_cnt[i] <= sel[i];
        else if (done)                    m_cnt[i] <= m_store[i];
        else if (en[i] && m_cnt[i] > 0)   m_cnt[i] <= m_cnt[i] - 1;
      end
      if (valid) for (int i = 0; i < 4; i++) m_store[i] <= sel[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("csle_count", int'(csle_cnt), m_cnt[0]);
      chk("ws_count",   int'(ws_cnt),   m_cnt[1]);
      chk("cste_count", int'(cste_cnt), m_cnt[2]);
      chk("csle_store", int'(csle_st),  m_store[0]);
      chk("ws_store",   int'(ws_st),    m_store[1]);
      chk("cste_store", int'(cste_st),  m_store[2]);
      chk("oete_store", int'(oete_st),  m_store[3]);
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    valid = 0; done = 0; le_en = 0; ws_en = 0; cste_en = 0;
  endtask

  initial begin
    tick(2);
    chk("reset_ws_count", int'(ws_cnt), 0);
    chk("reset_ws_store", int'(ws_st), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Load WS=0x40, count down a little, then reset asynchronously mid-count
    cs = 0; ws0 = 8'h40; csle0 = 2'd3; cste0 = 2'd1; oete0 = 2'd2; valid = 1;
    tick(); idle(); ws_en = 1;
    chk("ws_load_40", int'(ws_cnt), 64);
    tick(2);
    chk("ws_dec_3e", int'(ws_cnt), 62);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ws", int'(ws_cnt), 0);
    chk("async_rst_store", int'(ws_st), 0);
    chk("async_rst_oete", int'(oete_st), 0);
    tick();
    #2 rst_n = 1'b1;
    tick(3);
    chk("post_rst_ws", int'(ws_cnt), 0);
    chk("post_rst_csle", int'(csle_cnt), 0);
    idle();

    // cs=0 set: WS=3, CSLE=2
    cs = 0; ws0 = 8'd3; csle0 = 2'd2; valid = 1;
    tick(); idle();
    chk("load_ws3", int'(ws_cnt), 3);
    chk("load_csle2", int'(csle_cnt), 2);
    le_en = 1; ws_en = 1;
    tick(); chk("csle_1", int'(csle_cnt), 1); chk("ws_2", int'(ws_cnt), 2);
    tick(); chk("csle_0", int'(csle_cnt), 0); chk("ws_1", int'(ws_cnt), 1);
    le_en = 0;
    tick(); chk("ws_0", int'(ws_cnt), 0);
    tick(); chk("ws_sat0", int'(ws_cnt), 0);
    idle();

    // cs=1 set: CSTE=2, WS=0
    cs = 1; cste1 = 2'd2; ws1 = 8'd0; valid = 1;
    tick(); idle();
    chk("cste_store2", int'(cste_st), 2);
    cste_en = 1;
    tick(); chk("cste_1", int'(cste_cnt), 1);
    tick(); chk("cste_0", int'(cste_cnt), 0);
    tick(); chk("cste_sat0", int'(cste_cnt), 0);
    idle();

    // Multiple access: WS store 5, drain, reload on done; set changes ignored
    cs = 0; ws0 = 8'd5; valid = 1;
    tick(); idle(); ws_en = 1;
    tick(5);
    chk("ws_drained", int'(ws_cnt), 0);
    ws_en = 0; ws0 = 8'd77; done = 1;
    tick(); idle();
    chk("ws_reload5", int'(ws_cnt), 5);
    chk("ws_store5", int'(ws_st), 5);

    // Back-to-back: new access with done, new set wins
    cs = 1; ws1 = 8'd9; valid = 1; done = 1;
    tick(); idle();
    chk("b2b_ws9", int'(ws_cnt), 9);
    chk("b2b_store9", int'(ws_st), 9);

    // Load beats decrement
    cs = 0; ws0 = 8'd4; valid = 1;
    tick();
    ws0 = 8'd7; ws_en = 1;
    tick(); idle();
    chk("load_over_dec", int'(ws_cnt), 7);

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      valid   = ($urandom_range(0, 5) == 0);
      done    = ($urandom_range(0, 7) == 0);
      le_en   = 1'($urandom);
      ws_en   = ($urandom_range(0, 3) != 0);
      cste_en = 1'($urandom);
      cs      = 1'($urandom);
      csle0 = 2'($urandom); csle1 = 2'($urandom);
      cste0 = 2'($urandom); cste1 = 2'($urandom);
      oete0 = 2'($urandom); oete1 = 2'($urandom);
      ws0 = 8'($urandom_range(0, 12)); ws1 = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
